lcd_spi_slave: RTL and testbench
================================

LCD_SPI_SLAVE -- requirements
Module: lcd_spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port spi_sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-005 SHALL have port spi_mosi  input  1  master-out data.
REQ-006 SHALL have port spi_ss_n  input  1  active-low slave select.
REQ-007 SHALL have port spi_miso  output  1  slave-out data.
REQ-008 SHALL have port tx_data  input  DATA_W  next byte to transmit.
REQ-009 SHALL have port tx_valid  input  1  tx_data valid.
REQ-010 SHALL have port tx_ready  output  1  holding register empty.
REQ-011 SHALL have port rx_data  output  DATA_W  last received frame.
REQ-012 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data new.
REQ-013 SHALL have port busy  output  1  slave selected and mid-transfer.
REQ-014 SHALL have port tx_underrun  output  1  sticky: frame sent without loaded data.

Function
REQ-015 SHALL pass spi_sclk, spi_mosi, spi_ss_n through 2-flop synchronizers; a third sclk register provides edge detect.
REQ-016 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample MOSI on sclk rise, update MISO on sclk fall.
REQ-017 SHALL require clk >= 8x spi_sclk; behaviour outside this ratio is undefined.
REQ-018 SHALL use states IDLE, LOAD, SHIFT; IDLE->LOAD on synchronized ss_n falling; LOAD->SHIFT next cycle; SHIFT->IDLE on synchronized ss_n high.
REQ-019 SHALL in LOAD move holding register into tx shift register (tx_ready rises), or load all-ones and set tx_underrun if holding empty.
REQ-020 SHALL drive spi_miso = tx shift MSB while in LOAD/SHIFT and 0 in IDLE.
REQ-021 SHALL keep a bit counter 0..DATA_W-1, incremented on each detected sclk rise in SHIFT, wrapping to 0 after DATA_W-1.
REQ-022 SHALL on the rise that completes a frame copy rx shift (with the new bit) to rx_data and pulse rx_valid exactly one clk cycle, in the cycle after detection.
REQ-023 SHALL on the first sclk fall after a completed frame reload the tx shift register from holding (or all-ones plus tx_underrun), supporting back-to-back frames under one ss_n assertion.
REQ-024 SHALL accept tx_data when tx_valid && tx_ready; tx_ready deasserts next cycle until holding is consumed.
REQ-025 SHALL, if a holding load and a holding consume fall in the same cycle, consume the old value and store the new one (tx_ready stays low).
REQ-026 SHALL on ss_n deassert mid-frame discard the partial frame: no rx_valid, counter cleared, rx_data unchanged, holding register retained.
REQ-027 SHALL never pulse rx_valid for sclk edges seen while ss_n is high.
REQ-028 SHALL assert busy in LOAD and SHIFT only.

Reset
REQ-029 SHALL on reset force IDLE, counter 0, shift registers 0, rx_data 0, rx_valid 0, busy 0, spi_miso 0, tx_ready 1, tx_underrun 0, synchronizers to ss_n=1, sclk=0.
REQ-030 SHALL treat reset mid-transfer as abort: no rx_valid; transfer resumes only after a fresh ss_n fall.
REQ-031 SHALL hold tx_underrun until reset; it is not cleared by traffic.

Verification
REQ-032 Preload 0xA5, master sends 0x3C in one frame -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse, tx_ready back to 1.
REQ-033 Preload 0x11, then 0x22 during frame 1; two frames 0xDE,0xAD under one ss_n -> master reads 0x11,0x22; two rx_valid pulses, rx_data 0xDE then 0xAD.
REQ-034 No preload, one frame 0x55 -> master reads 0xFF, tx_underrun=1 and stays 1 after further good frames.
REQ-035 ss_n raised after 5 sclk rises, then full frame 0x81 -> no rx_valid for partial, rx_data=0x81 after second frame only.
REQ-036 reset asserted after 3 bits of frame -> all outputs at REQ-029 values next cycle; sclk toggles with ss_n still low produce no rx_valid.
REQ-037 Random bytes, clk/sclk ratio 8 and 13, 200 frames -> scoreboard matches every rx and tx byte.

Source files
------------

// File: rtl/lcd_spi_slave.sv
// SPI mode-0 slave (MSB first) for an LCD link, with one transmit holding register and a sticky underrun flag.
// Every SPI pin is synchronised into clk; the design needs clk to run at least 8x sclk.
module lcd_spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, next_state;

  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              mosi_s1, mosi_s2;
  logic              ss_s1, ss_s2, ss_prev;
  logic [1:0]        sync_ok;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift, rx_shift, hold;
  logic              hold_full, frame_done, pend_consume, pend_underrun;

  logic ss_fall, sclk_rise, sclk_fall, shifting, shift_rise, shift_fall;
  logic last_bit, accept, consume_now, underrun_now;

  // ss_prev only follows ss_s2 once the synchronisers carry real samples, so a
  // slave select already low when reset drops never counts as a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_prev <= 1'b0;
      sync_ok <= 2'b00;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= spi_ss_n;
      ss_s2   <= ss_s1;
      ss_prev <= sync_ok[1] & ss_s2;
      sync_ok <= {sync_ok[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    ss_fall      = ss_prev & ~ss_s2;
    sclk_rise    = sclk_s2 & ~sclk_s3;
    sclk_fall    = ~sclk_s2 & sclk_s3;
    shifting     = (state == SHIFT) && !ss_s2;
    shift_rise   = shifting && sclk_rise;
    shift_fall   = shifting && sclk_fall;
    last_bit     = (bit_cnt == CNT_W'(DATA_W - 1));
    accept       = tx_valid && !hold_full;
    consume_now  = ((state == LOAD) && hold_full) || (shift_rise && pend_consume);
    underrun_now = ((state == LOAD) && !hold_full) || (shift_rise && pend_underrun);
    case (state)
      IDLE:    if (ss_fall) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (ss_s2) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign spi_miso = (state != IDLE) && tx_shift[DATA_W-1];
  assign tx_ready = !hold_full;

  // The reload at a frame boundary copies the holding register but only retires
  // it (or flags underrun) on the next frame's first rise: if ss_n closes the
  // transfer instead, the byte stays queued for the next LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      bit_cnt       <= '0;
      frame_done    <= 1'b0;
      pend_consume  <= 1'b0;
      pend_underrun <= 1'b0;
      tx_underrun   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (consume_now) begin
        hold_full <= 1'b0;
      end
      if (underrun_now) tx_underrun <= 1'b1;

      if (state == LOAD) begin
        tx_shift      <= hold_full ? hold : '1;
        bit_cnt       <= '0;
        frame_done    <= 1'b0;
        pend_consume  <= 1'b0;
        pend_underrun <= 1'b0;
      end else if (shifting) begin
        if (sclk_rise) begin
          rx_shift      <= {rx_shift[DATA_W-2:0], mosi_s2};
          pend_consume  <= 1'b0;
          pend_underrun <= 1'b0;
          if (last_bit) begin
            bit_cnt    <= '0;
            rx_data    <= {rx_shift[DATA_W-2:0], mosi_s2};
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (sclk_fall) begin
          if (frame_done) begin
            tx_shift      <= hold_full ? hold : '1;
            pend_consume  <= hold_full;
            pend_underrun <= !hold_full;
            frame_done    <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end else begin
        bit_cnt       <= '0;
        frame_done    <= 1'b0;
        pend_consume  <= 1'b0;
        pend_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_slave.sv
// Bench for lcd_spi_slave: a behavioural SPI master plus a transmit feeder,
// with received and transmitted bytes scored against expected byte lists.
module tb_lcd_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_mosi, spi_ss_n, spi_miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy, tx_underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int lo = 4;
  int hi = 4;

  logic [7:0] feed_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_exp[200];
  logic [7:0] rx_exp[200];
  logic [7:0] s1, s2;

  lcd_spi_slave #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx_got.size()) return 32'(rx_got[i]);
    return 32'hdead_beef;
  endfunction

  // Mode 0 master: MOSI set while sclk low, MISO sampled just before the rise.
  task automatic spi_byte(input logic [7:0] m, input int nbits, output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = m[7-i];
      wclk(lo);
      s[7-i] = spi_miso;
      spi_sclk = 1'b1;
      wclk(hi);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    spi_ss_n = 1'b0;
    wclk(6);
  endtask

  task automatic ss_end();
    wclk(lo);
    spi_ss_n = 1'b1;
    wclk(6);
  endtask

  // Feeder hands queued bytes to the holding register whenever it is free.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      if (!reset && tx_ready && feed_q.size() > 0) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) if (rx_valid) rx_got.push_back(rx_data);

  initial begin
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    wclk(3);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    reset = 1'b0;
    wclk(8);

    // Single frame with preloaded byte.
    feed_q.push_back(8'hA5);
    wclk(3);
    chk("preload_not_ready", 32'(tx_ready), 32'd0);
    ss_begin();
    chk("busy_selected", 32'(busy), 32'd1);
    chk("ready_after_load", 32'(tx_ready), 32'd1);
    spi_byte(8'h3C, 8, s1);
    ss_end();
    chk("single_miso", 32'(s1), 32'hA5);
    chk("single_rx_count", 32'(rx_got.size()), 32'd1);
    chk("single_rx_data", rx_at(0), 32'h3C);
    chk("single_busy_idle", 32'(busy), 32'd0);
    chk("single_no_underrun", 32'(tx_underrun), 32'd0);

    // Back-to-back frames under one select.
    rx_got.delete();
    feed_q.push_back(8'h11);
    feed_q.push_back(8'h22);
    wclk(3);
    ss_begin();
    spi_byte(8'hDE, 8, s1);
    spi_byte(8'hAD, 8, s2);
    ss_end();
    chk("b2b_miso0", 32'(s1), 32'h11);
    chk("b2b_miso1", 32'(s2), 32'h22);
    chk("b2b_rx_count", 32'(rx_got.size()), 32'd2);
    chk("b2b_rx0", rx_at(0), 32'hDE);
    chk("b2b_rx1", rx_at(1), 32'hAD);
    chk("b2b_tx_ready", 32'(tx_ready), 32'd1);

    // Partial frame aborted by ss_n, then a full frame.
    rx_got.delete();
    feed_q.push_back(8'h5A);
    feed_q.push_back(8'h77);
    wclk(3);
    ss_begin();
    spi_byte(8'hF0, 5, s1);
    ss_end();
    chk("partial_rx_count", 32'(rx_got.size()), 32'd0);
    chk("partial_rx_data_kept", 32'(rx_data), 32'hAD);
    chk("partial_hold_kept", 32'(tx_ready), 32'd0);
    ss_begin();
    spi_byte(8'h81, 8, s1);
    ss_end();
    chk("after_partial_miso", 32'(s1), 32'h77);
    chk("after_partial_rx_count", 32'(rx_got.size()), 32'd1);
    chk("after_partial_rx", rx_at(0), 32'h81);

    // Reset mid-transfer with ss_n held low.
    rx_got.delete();
    ss_begin();
    spi_byte(8'hE7, 3, s1);
    reset = 1'b1;
    wclk(1);
    reset = 1'b0;
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_miso", 32'(spi_miso), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_underrun", 32'(tx_underrun), 32'd0);
    spi_byte(8'hC3, 8, s1);
    spi_byte(8'h3C, 8, s1);
    chk("midrst_no_rx", 32'(rx_got.size()), 32'd0);
    chk("midrst_still_idle", 32'(busy), 32'd0);
    ss_end();

    // Underrun: nothing loaded, then a good frame keeps the flag.
    rx_got.delete();
    ss_begin();
    spi_byte(8'h55, 8, s1);
    ss_end();
    chk("underrun_miso", 32'(s1), 32'hFF);
    chk("underrun_flag", 32'(tx_underrun), 32'd1);
    chk("underrun_rx", rx_at(0), 32'h55);
    feed_q.push_back(8'h12);
    wclk(3);
    ss_begin();
    spi_byte(8'h66, 8, s1);
    ss_end();
    chk("underrun_good_miso", 32'(s1), 32'h12);
    chk("underrun_sticky", 32'(tx_underrun), 32'd1);

    // Randomised traffic: groups of 1-4 frames, clk/sclk ratio 8 or 13.
    reset = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(8);
    rx_got.delete();
    for (int i = 0; i < 200; i++) begin
      tx_exp[i] = 8'($urandom);
      rx_exp[i] = 8'($urandom);
      feed_q.push_back(tx_exp[i]);
    end
    wclk(3);
    begin
      int frames = 0;
      while (frames < 200) begin
        int grp = $urandom_range(1, 4);
        if ($urandom_range(0, 1) == 0) begin lo = 4; hi = 4; end
        else begin lo = 7; hi = 6; end
        ss_begin();
        for (int k = 0; k < grp && frames < 200; k++) begin
          spi_byte(rx_exp[frames], 8, s1);
          chk("rand_miso", 32'(s1), 32'(tx_exp[frames]));
          frames++;
        end
        ss_end();
      end
    end
    chk("rand_rx_count", 32'(rx_got.size()), 32'd200);
    for (int i = 0; i < 200; i++) chk("rand_rx", rx_at(i), 32'(rx_exp[i]));
    chk("rand_no_underrun", 32'(tx_underrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
